stack_cache: RTL and testbench

//   Parametrised data/return stack engine for the stack CPU family. It keeps
//   the top DEPTH entries in on-chip registers and presents TOS/NOS to the
//   ALU each cycle. It spills the oldest entry to memory on push-when-full,
//   and refills from memory when fewer than 2 entries remain on chip.
//   One instance per stack (data, return); the control FSM issues the ops.

---
 rtl/stack_cache_if.sv | 45 ++++
 rtl/stack_cache.sv | 261 ++++++++++++++++++++++++++
 tb/tb_stack_cache.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/stack_cache_if.sv
// stack_cache_if
//   Bundles the op channel, the TOS/NOS/depth result view, the spill/fill
//   memory port and the sticky error flags of one stack_cache instance.
//   modport slave  : the stack cache itself
//   modport master : the control FSM / memory side driving ops and answering
//                    memory requests
//   Signals:
//     op_valid, op, push_data, op_ready        op request channel
//     tos, nos, depth                          stack view presented each cycle
//     mem_req, mem_we, mem_addr, mem_wdata,
//     mem_rdata, mem_ack                       spill/fill memory port
//     overflow, underflow, err_clr             sticky error flags and clear
interface stack_cache_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 16
);
    logic              op_valid;
    logic              op_ready;
    logic [1:0]        op;
    logic [WIDTH-1:0]  push_data;
    logic [WIDTH-1:0]  tos;
    logic [WIDTH-1:0]  nos;
    logic [ADDR_W:0]   depth;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic [WIDTH-1:0]  mem_rdata;
    logic              mem_ack;
    logic              overflow;
    logic              underflow;
    logic              err_clr;

    modport slave (
        input  op_valid, op, push_data, mem_rdata, mem_ack, err_clr,
        output op_ready, tos, nos, depth, mem_req, mem_we, mem_addr,
               mem_wdata, overflow, underflow
    );

    modport master (
        output op_valid, op, push_data, mem_rdata, mem_ack, err_clr,
        input  op_ready, tos, nos, depth, mem_req, mem_we, mem_addr,
               mem_wdata, overflow, underflow
    );
endinterface

// File: rtl/stack_cache.sv
// stack_cache
//   Data/return stack engine. Keeps the top DEPTH entries in a circular
//   register buffer (bot_r points at the oldest on-chip entry), spills the
//   oldest entry to memory on a push into a full buffer and refills from
//   memory while fewer than two entries are on chip.
//   Ports:
//     clk    clock
//     reset  synchronous, active-high
//     bus    stack_cache_if.slave (op channel, stack view, memory port, flags)
//   Every output is a register loaded from the computed next state, so the
//   result of an op is visible the cycle after it is accepted.
module stack_cache #(
    parameter int                WIDTH     = 16,
    parameter int                DEPTH     = 4,
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE      = 16'hFF00,
    parameter int                MEM_DEPTH = 256,
    parameter bit                GROW_UP   = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    stack_cache_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int MW = ADDR_W + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SPILL = 2'd1;
    localparam logic [1:0] ST_FILL  = 2'd2;

    localparam logic [1:0] OP_PUSH = 2'd0;
    localparam logic [1:0] OP_POP  = 2'd1;
    localparam logic [1:0] OP_REPL = 2'd2;
    localparam logic [1:0] OP_SWAP = 2'd3;

    localparam logic [CW-1:0]     CC_ONE  = CW'(1);
    localparam logic [CW-1:0]     CC_TWO  = CW'(2);
    localparam logic [CW-1:0]     CC_FULL = CW'(DEPTH);
    localparam logic [MW-1:0]     MC_ZERO = {MW{1'b0}};
    localparam logic [MW-1:0]     MC_ONE  = MW'(1);
    localparam logic [MW-1:0]     MC_FULL = MW'(MEM_DEPTH);
    localparam logic [PW-1:0]     IX_ONE  = PW'(1);
    localparam logic [ADDR_W-1:0] AD_ONE  = ADDR_W'(1);
    localparam logic [WIDTH-1:0]  W_ZERO  = {WIDTH{1'b0}};

    // Memory address of spill slot k; wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] slot_addr(input logic [ADDR_W-1:0] slot);
        if (GROW_UP) begin
            return BASE + slot;
        end else begin
            return BASE - slot;
        end
    endfunction

    logic [1:0]        state_r, state_nxt;
    logic [WIDTH-1:0]  stk_r   [DEPTH];
    logic [WIDTH-1:0]  stk_nxt [DEPTH];
    logic [PW-1:0]     bot_r, bot_nxt;
    logic [CW-1:0]     cc_r, cc_nxt;
    logic [MW-1:0]     mc_r, mc_nxt;
    logic [WIDTH-1:0]  latch_r, latch_nxt;
    logic              ovf_r, ovf_nxt;
    logic              unf_r, unf_nxt;
    logic [WIDTH-1:0]  tos_r, tos_nxt;
    logic [WIDTH-1:0]  nos_r, nos_nxt;
    logic [MW-1:0]     depth_r, depth_nxt;
    logic              mem_req_r, mem_req_nxt;
    logic              mem_we_r, mem_we_nxt;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_nxt;
    logic [WIDTH-1:0]  mem_wdata_r, mem_wdata_nxt;
    logic              op_ready_r;

    logic [PW-1:0]     top_ix_s, nos_ix_s, free_ix_s, below_ix_s;
    logic [PW-1:0]     ntop_ix_s, nnos_ix_s;
    logic [ADDR_W-1:0] slot_s;

    // Buffer positions derived from the current state (cc_r == DEPTH wraps
    // free_ix_s onto bot_r, which is only used when not full).
    always_comb begin
        free_ix_s  = bot_r + cc_r[PW-1:0];
        top_ix_s   = free_ix_s - IX_ONE;
        nos_ix_s   = top_ix_s - IX_ONE;
        below_ix_s = bot_r - IX_ONE;
    end

    // Next-state logic: op execution, spill and fill sequencing, sticky flags.
    always_comb begin
        state_nxt = state_r;
        stk_nxt   = stk_r;
        bot_nxt   = bot_r;
        cc_nxt    = cc_r;
        mc_nxt    = mc_r;
        latch_nxt = latch_r;
        // A set further down overrides the clear, giving set priority.
        ovf_nxt   = bus.err_clr ? 1'b0 : ovf_r;
        unf_nxt   = bus.err_clr ? 1'b0 : unf_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.op_valid) begin
                    case (bus.op)
                        OP_PUSH: begin
                            if (cc_r < CC_FULL) begin
                                stk_nxt[free_ix_s] = bus.push_data;
                                cc_nxt             = cc_r + CC_ONE;
                            end else if (mc_r < MC_FULL) begin
                                latch_nxt = bus.push_data;
                                state_nxt = ST_SPILL;
                            end else begin
                                ovf_nxt = 1'b1;
                            end
                        end
                        OP_POP: begin
                            if (cc_r >= CC_ONE) begin
                                cc_nxt = cc_r - CC_ONE;
                            end else begin
                                unf_nxt = 1'b1;
                            end
                        end
                        OP_REPL: begin
                            if (cc_r >= CC_ONE) begin
                                stk_nxt[top_ix_s] = bus.push_data;
                            end else begin
                                unf_nxt = 1'b1;
                            end
                        end
                        OP_SWAP: begin
                            if (cc_r >= CC_TWO) begin
                                stk_nxt[top_ix_s] = stk_r[nos_ix_s];
                                stk_nxt[nos_ix_s] = stk_r[top_ix_s];
                            end else begin
                                unf_nxt = 1'b1;
                            end
                        end
                        default: begin
                            state_nxt = ST_IDLE;
                        end
                    endcase
                end else if ((cc_r < CC_TWO) && (mc_r != MC_ZERO)) begin
                    // Refill only in cycles where no op is presented.
                    state_nxt = ST_FILL;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SPILL: begin
                if (bus.mem_ack) begin
                    // The buffer is full, so the freed bottom slot is exactly
                    // where the new top lands.
                    stk_nxt[bot_r] = latch_r;
                    bot_nxt        = bot_r + IX_ONE;
                    mc_nxt         = mc_r + MC_ONE;
                    state_nxt      = ST_IDLE;
                end else begin
                    state_nxt = ST_SPILL;
                end
            end
            ST_FILL: begin
                if (bus.mem_ack) begin
                    stk_nxt[below_ix_s] = bus.mem_rdata;
                    bot_nxt             = below_ix_s;
                    cc_nxt              = cc_r + CC_ONE;
                    mc_nxt              = mc_r - MC_ONE;
                    state_nxt           = ST_IDLE;
                end else begin
                    state_nxt = ST_FILL;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output values computed from the next state so outputs are plain registers.
    always_comb begin
        ntop_ix_s = bot_nxt + cc_nxt[PW-1:0] - IX_ONE;
        nnos_ix_s = ntop_ix_s - IX_ONE;
        if (cc_nxt >= CC_ONE) begin
            tos_nxt = stk_nxt[ntop_ix_s];
        end else begin
            tos_nxt = W_ZERO;
        end
        if (cc_nxt >= CC_TWO) begin
            nos_nxt = stk_nxt[nnos_ix_s];
        end else begin
            nos_nxt = W_ZERO;
        end
        depth_nxt   = MW'(cc_nxt) + mc_nxt;
        mem_req_nxt = (state_nxt != ST_IDLE);
        mem_we_nxt  = (state_nxt == ST_SPILL);
        // Spill writes the slot just above the spilled region, fill reads its top.
        if (state_nxt == ST_FILL) begin
            slot_s = mc_nxt[ADDR_W-1:0] - AD_ONE;
        end else begin
            slot_s = mc_nxt[ADDR_W-1:0];
        end
        if (state_nxt != ST_IDLE) begin
            mem_addr_nxt = slot_addr(slot_s);
        end else begin
            mem_addr_nxt = {ADDR_W{1'b0}};
        end
        if (state_nxt == ST_SPILL) begin
            mem_wdata_nxt = stk_nxt[bot_nxt];
        end else begin
            mem_wdata_nxt = W_ZERO;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                stk_r[i] <= W_ZERO;
            end
            bot_r       <= {PW{1'b0}};
            cc_r        <= {CW{1'b0}};
            mc_r        <= MC_ZERO;
            latch_r     <= W_ZERO;
            ovf_r       <= 1'b0;
            unf_r       <= 1'b0;
            tos_r       <= W_ZERO;
            nos_r       <= W_ZERO;
            depth_r     <= MC_ZERO;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= W_ZERO;
            op_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_nxt;
            stk_r       <= stk_nxt;
            bot_r       <= bot_nxt;
            cc_r        <= cc_nxt;
            mc_r        <= mc_nxt;
            latch_r     <= latch_nxt;
            ovf_r       <= ovf_nxt;
            unf_r       <= unf_nxt;
            tos_r       <= tos_nxt;
            nos_r       <= nos_nxt;
            depth_r     <= depth_nxt;
            mem_req_r   <= mem_req_nxt;
            mem_we_r    <= mem_we_nxt;
            mem_addr_r  <= mem_addr_nxt;
            mem_wdata_r <= mem_wdata_nxt;
            op_ready_r  <= (state_nxt == ST_IDLE);
        end
    end

    assign bus.op_ready  = op_ready_r;
    assign bus.tos       = tos_r;
    assign bus.nos       = nos_r;
    assign bus.depth     = depth_r;
    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.overflow  = ovf_r;
    assign bus.underflow = unf_r;
endmodule

// File: tb/tb_stack_cache.sv
// tb_stack_cache
//   Directed bench for stack_cache with DEPTH=4, MEM_DEPTH=2, BASE=16'hFF00,
//   GROW_UP=1. Inputs change on the falling edge, outputs are checked on the
//   falling edge after the rising edge that updated them.
module tb_stack_cache;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    stack_cache_if #(.WIDTH(16), .ADDR_W(16)) sif ();

    stack_cache #(
        .WIDTH(16), .DEPTH(4), .ADDR_W(16), .BASE(16'hFF00),
        .MEM_DEPTH(2), .GROW_UP(1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    task automatic idle_inputs();
        sif.op_valid  = 1'b0;
        sif.op        = 2'd0;
        sif.push_data = 16'h0000;
        sif.mem_rdata = 16'h0000;
        sif.mem_ack   = 1'b0;
        sif.err_clr   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // One-cycle op; returns on the falling edge after it was taken.
    task automatic issue(input logic [1:0] op, input logic [15:0] data);
        sif.op_valid  = 1'b1;
        sif.op        = op;
        sif.push_data = data;
        @(posedge clk);
        @(negedge clk);
        sif.op_valid  = 1'b0;
    endtask

    task automatic mem_ack_now(input logic [15:0] rdata);
        sif.mem_rdata = rdata;
        sif.mem_ack   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sif.mem_ack   = 1'b0;
    endtask

    task automatic wait_req(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (sif.mem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!ok) begin bad++; $display("FAIL %s_timeout got=no mem_req want=mem_req within 8 cycles", name); end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (sif.tos !== 16'h0000) begin bad++; $display("FAIL rst_tos got=%h want=0000", sif.tos); end
        total++; if (sif.nos !== 16'h0000) begin bad++; $display("FAIL rst_nos got=%h want=0000", sif.nos); end
        total++; if (sif.depth !== 17'd0) begin bad++; $display("FAIL rst_depth got=%0d want=0", sif.depth); end
        total++; if (sif.mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%b want=0", sif.mem_req); end
        total++; if (sif.op_ready !== 1'b1) begin bad++; $display("FAIL rst_op_ready got=%b want=1", sif.op_ready); end
        total++; if ({sif.overflow, sif.underflow} !== 2'b00) begin bad++; $display("FAIL rst_flags got=%b want=00", {sif.overflow, sif.underflow}); end
    endtask

    task automatic test_push_pop();
        do_reset();
        issue(2'd0, 16'd1);
        issue(2'd0, 16'd2);
        issue(2'd0, 16'd3);
        total++; if (sif.tos !== 16'd3) begin bad++; $display("FAIL pp_tos got=%h want=0003", sif.tos); end
        total++; if (sif.nos !== 16'd2) begin bad++; $display("FAIL pp_nos got=%h want=0002", sif.nos); end
        total++; if (sif.depth !== 17'd3) begin bad++; $display("FAIL pp_depth got=%0d want=3", sif.depth); end
        total++; if (sif.mem_req !== 1'b0) begin bad++; $display("FAIL pp_mem_req got=%b want=0", sif.mem_req); end
        issue(2'd1, 16'd0);
        total++; if (sif.tos !== 16'd2) begin bad++; $display("FAIL pp_pop_tos got=%h want=0002", sif.tos); end
        total++; if (sif.nos !== 16'd1) begin bad++; $display("FAIL pp_pop_nos got=%h want=0001", sif.nos); end
        total++; if (sif.depth !== 17'd2) begin bad++; $display("FAIL pp_pop_depth got=%0d want=2", sif.depth); end
    endtask

    task automatic test_spill();
        do_reset();
        for (int k = 1; k <= 5; k++) issue(2'd0, 16'(k));
        total++; if ({sif.mem_req, sif.mem_we} !== 2'b11) begin bad++; $display("FAIL sp_req_we got=%b want=11", {sif.mem_req, sif.mem_we}); end
        total++; if (sif.mem_addr !== 16'hFF00) begin bad++; $display("FAIL sp_addr got=%h want=ff00", sif.mem_addr); end
        total++; if (sif.mem_wdata !== 16'd1) begin bad++; $display("FAIL sp_wdata got=%h want=0001", sif.mem_wdata); end
        total++; if (sif.op_ready !== 1'b0) begin bad++; $display("FAIL sp_busy got=%b want=0", sif.op_ready); end
        repeat (2) @(negedge clk);
        total++; if ({sif.mem_req, sif.mem_addr, sif.mem_wdata} !== {1'b1, 16'hFF00, 16'd1}) begin bad++; $display("FAIL sp_hold got=%b/%h/%h want=1/ff00/0001", sif.mem_req, sif.mem_addr, sif.mem_wdata); end
        mem_ack_now(16'h0000);
        total++; if (sif.tos !== 16'd5) begin bad++; $display("FAIL sp_tos got=%h want=0005", sif.tos); end
        total++; if (sif.nos !== 16'd4) begin bad++; $display("FAIL sp_nos got=%h want=0004", sif.nos); end
        total++; if (sif.depth !== 17'd5) begin bad++; $display("FAIL sp_depth got=%0d want=5", sif.depth); end
        total++; if ({sif.op_ready, sif.mem_req} !== 2'b10) begin bad++; $display("FAIL sp_done got=%b want=10", {sif.op_ready, sif.mem_req}); end
    endtask

    // Continues from test_spill: stack is 1 (mem) | 2,3,4,5 (chip).
    task automatic test_overflow();
        issue(2'd0, 16'd6);
        total++; if ({sif.mem_req, sif.mem_we, sif.mem_addr} !== {2'b11, 16'hFF01}) begin bad++; $display("FAIL ov_spill got=%b%b/%h want=11/ff01", sif.mem_req, sif.mem_we, sif.mem_addr); end
        total++; if (sif.mem_wdata !== 16'd2) begin bad++; $display("FAIL ov_wdata got=%h want=0002", sif.mem_wdata); end
        mem_ack_now(16'h0000);
        total++; if ({sif.depth, sif.tos} !== {17'd6, 16'd6}) begin bad++; $display("FAIL ov_d6 got=%0d/%h want=6/0006", sif.depth, sif.tos); end
        issue(2'd0, 16'd7);
        total++; if (sif.overflow !== 1'b1) begin bad++; $display("FAIL ov_flag got=%b want=1", sif.overflow); end
        total++; if ({sif.depth, sif.tos, sif.nos} !== {17'd6, 16'd6, 16'd5}) begin bad++; $display("FAIL ov_nochg got=%0d/%h/%h want=6/0006/0005", sif.depth, sif.tos, sif.nos); end
        total++; if ({sif.mem_req, sif.op_ready} !== 2'b01) begin bad++; $display("FAIL ov_idle got=%b want=01", {sif.mem_req, sif.op_ready}); end
    endtask

    // Continues from test_overflow: stack is 1,2 (mem) | 3,4,5,6 (chip).
    task automatic test_fill();
        issue(2'd1, 16'd0);
        issue(2'd1, 16'd0);
        issue(2'd1, 16'd0);
        total++; if ({sif.tos, sif.nos, sif.depth} !== {16'd3, 16'd0, 17'd3}) begin bad++; $display("FAIL fl_pop got=%h/%h/%0d want=0003/0000/3", sif.tos, sif.nos, sif.depth); end
        wait_req("fl_1");
        total++; if ({sif.mem_we, sif.mem_addr} !== {1'b0, 16'hFF01}) begin bad++; $display("FAIL fl_rd1 got=%b/%h want=0/ff01", sif.mem_we, sif.mem_addr); end
        mem_ack_now(16'd2);
        total++; if ({sif.tos, sif.nos, sif.depth} !== {16'd3, 16'd2, 17'd3}) begin bad++; $display("FAIL fl_after1 got=%h/%h/%0d want=0003/0002/3", sif.tos, sif.nos, sif.depth); end
        repeat (3) @(negedge clk);
        total++; if ({sif.mem_req, sif.op_ready} !== 2'b01) begin bad++; $display("FAIL fl_stop got=%b want=01", {sif.mem_req, sif.op_ready}); end
        issue(2'd1, 16'd0);
        wait_req("fl_2");
        total++; if ({sif.mem_we, sif.mem_addr} !== {1'b0, 16'hFF00}) begin bad++; $display("FAIL fl_rd2 got=%b/%h want=0/ff00", sif.mem_we, sif.mem_addr); end
        mem_ack_now(16'd1);
        total++; if ({sif.tos, sif.nos, sif.depth} !== {16'd2, 16'd1, 17'd2}) begin bad++; $display("FAIL fl_after2 got=%h/%h/%0d want=0002/0001/2", sif.tos, sif.nos, sif.depth); end
        total++; if (sif.overflow !== 1'b1) begin bad++; $display("FAIL fl_ovf_sticky got=%b want=1", sif.overflow); end
    endtask

    task automatic test_underflow_swap();
        do_reset();
        issue(2'd1, 16'd0);
        total++; if ({sif.underflow, sif.tos, sif.depth} !== {1'b1, 16'd0, 17'd0}) begin bad++; $display("FAIL uf_pop got=%b/%h/%0d want=1/0000/0", sif.underflow, sif.tos, sif.depth); end
        issue(2'd3, 16'd0);
        total++; if ({sif.underflow, sif.tos} !== {1'b1, 16'd0}) begin bad++; $display("FAIL uf_swap got=%b/%h want=1/0000", sif.underflow, sif.tos); end
        sif.err_clr = 1'b1;
        @(posedge clk); @(negedge clk);
        sif.err_clr = 1'b0;
        total++; if (sif.underflow !== 1'b0) begin bad++; $display("FAIL uf_clr got=%b want=0", sif.underflow); end
        sif.err_clr = 1'b1;
        issue(2'd2, 16'h1111);
        sif.err_clr = 1'b0;
        total++; if (sif.underflow !== 1'b1) begin bad++; $display("FAIL uf_set_prio got=%b want=1", sif.underflow); end
        issue(2'd0, 16'hAAAA);
        issue(2'd0, 16'hBBBB);
        issue(2'd3, 16'd0);
        total++; if ({sif.tos, sif.nos} !== {16'hAAAA, 16'hBBBB}) begin bad++; $display("FAIL sw_result got=%h/%h want=aaaa/bbbb", sif.tos, sif.nos); end
        issue(2'd2, 16'h1234);
        total++; if ({sif.tos, sif.nos, sif.depth} !== {16'h1234, 16'hBBBB, 17'd2}) begin bad++; $display("FAIL repl_result got=%h/%h/%0d want=1234/bbbb/2", sif.tos, sif.nos, sif.depth); end
    endtask

    task automatic test_reset_mid_spill();
        do_reset();
        for (int k = 1; k <= 5; k++) issue(2'd0, 16'(k));
        total++; if (sif.mem_req !== 1'b1) begin bad++; $display("FAIL rs_spill got=%b want=1", sif.mem_req); end
        reset       = 1'b1;
        sif.mem_ack = 1'b1;
        @(posedge clk); @(negedge clk);
        reset       = 1'b0;
        sif.mem_ack = 1'b0;
        total++; if ({sif.mem_req, sif.op_ready} !== 2'b01) begin bad++; $display("FAIL rs_abort got=%b want=01", {sif.mem_req, sif.op_ready}); end
        total++; if ({sif.depth, sif.tos} !== {17'd0, 16'd0}) begin bad++; $display("FAIL rs_state got=%0d/%h want=0/0000", sif.depth, sif.tos); end
        @(negedge clk);
        total++; if ({sif.mem_req, sif.depth} !== {1'b0, 17'd0}) begin bad++; $display("FAIL rs_settle got=%b/%0d want=0/0", sif.mem_req, sif.depth); end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_push_pop();
        test_spill();
        test_overflow();
        test_fill();
        test_underflow_swap();
        test_reset_mid_spill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
